// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module  : cpu_pkg
//  Brief   : Shared types and constants for the instruction-fetch front end.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int IFQ_ADDR_W  = 32;
  localparam int IFQ_DATA_W  = 32;
  localparam int IFQ_PC_STEP = 4;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instr;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_e;

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ============================================================================
//  Module  : ifq_fifo
//  Brief   : DEPTH-entry synchronous FIFO with flush; flush beats push/pop.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifq_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  T                       data_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop_i && (r_count != '0);
  // A full queue only accepts a push when a pop frees the slot the same cycle.
  assign w_push = push_i && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ============================================================================
//  Module  : if_fetch_queue
//  Brief   : Fetch PC owner, credit-limited imem requester and fetch queue.
//            Optional same-cycle bypass into IF/ID under IFQ_BYPASS_EN.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   redirect_i,
  input  logic [ADDR_W-1:0]      redirect_pc_i,
  output logic                   imem_req_o,
  output logic [ADDR_W-1:0]      imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [DATA_W-1:0]      imem_rdata_i,
  input  logic                   deq_ready_i,
  output logic                   deq_valid_o,
  output logic [DATA_W-1:0]      deq_instr_o,
  output logic [ADDR_W-1:0]      deq_pc_o,
  output logic [ADDR_W-1:0]      deq_pc4_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(IFQ_PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  ifq_state_e        r_state;
  ifq_state_e        w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discard_cnt;
  logic [CNT_W-1:0]  w_discard_next;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_credit_used;
  logic              w_grant;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_entry;
  entry_t            w_head;

  assign w_grant        = imem_req_o && imem_gnt_i;
  assign w_accept       = imem_rvalid_i && (r_discard_cnt == '0) && !redirect_i;
  // Everything still in flight after this cycle belongs to the old path.
  assign w_discard_next = r_outstanding - CNT_W'(imem_rvalid_i);
  assign w_credit_used  = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_pop          = (w_count != '0) && deq_ready_i && !redirect_i;
  assign w_push_entry   = '{pc: r_resp_pc, instr: imem_rdata_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_next = RUN;
      RUN:     if (!start_i && (r_outstanding == '0)) w_state_next = IDLE;
      DRAIN:   if (r_discard_cnt == '0) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
    if (redirect_i && (w_discard_next != '0)) w_state_next = DRAIN;
  end

  always_comb begin
    imem_req_o = 1'b0;
    if ((r_state != IDLE) && start_i && !redirect_i &&
        (w_credit_used < (CNT_W+1)'(DEPTH)))
      imem_req_o = 1'b1;
  end

  assign imem_addr_o = r_fetch_pc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid_i);
      if (redirect_i) begin
        r_fetch_pc    <= redirect_pc_i;
        r_resp_pc     <= redirect_pc_i;
        r_discard_cnt <= w_discard_next;
      end else begin
        if (w_grant)  r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_accept) r_resp_pc  <= r_resp_pc + PC_STEP;
        if (imem_rvalid_i && (r_discard_cnt != '0))
          r_discard_cnt <= r_discard_cnt - CNT_W'(1);
      end
    end
  end

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_accept && (w_count == '0) && deq_ready_i;
  assign w_push      = w_accept && !w_bypass;
  assign deq_valid_o = (w_count != '0) || w_bypass;
  assign deq_instr_o = w_bypass ? imem_rdata_i : w_head.instr;
  assign deq_pc_o    = w_bypass ? r_resp_pc : w_head.pc;
`else
  assign w_push      = w_accept;
  assign deq_valid_o = (w_count != '0);
  assign deq_instr_o = w_head.instr;
  assign deq_pc_o    = w_head.pc;
`endif

  assign deq_pc4_o = deq_pc_o + PC_STEP;
  assign count_o   = w_count;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .data_i  (w_push_entry),
    .data_o  (w_head),
    .count_o (w_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus randomized traffic against
// an epoch-based model of the fetch stream and a variable-latency memory.
`default_nettype none

module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, redirect_i, imem_gnt_i, imem_rvalid_i, deq_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, deq_valid_o;
  logic [31:0] imem_addr_o, deq_instr_o, deq_pc_o, deq_pc4_o;
  logic [2:0]  count_o;

  if_fetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .deq_ready_i(deq_ready_i), .deq_valid_o(deq_valid_o), .deq_instr_o(deq_instr_o),
    .deq_pc_o(deq_pc_o), .deq_pc4_o(deq_pc4_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];   // granted requests not yet answered, in order
  logic [31:0] mq[$];     // PCs expected to sit in the queue
  logic [31:0] m_fetch_pc;
  int          epoch, cyc, lat_min, lat_max;
  int          vectors, miscompares;
  bit          m_active, resp_live, m_byp, exp_req, exp_valid;
  logic [31:0] exp_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; deq_ready_i = 1'b0;
    pend.delete(); mq.delete();
    m_fetch_pc = RESET_PC; m_active = 1'b0; epoch = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  // Drive the memory response for this cycle and derive the expected outputs.
  task automatic prepare();
    resp_live = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memf(pend[0].addr);
      resp_live     = (pend[0].epoch == epoch);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom();
    end
    #1;
    exp_req = m_active && start_i && !redirect_i && (mq.size() + pend.size() < DEPTH);
`ifdef IFQ_BYPASS_EN
    m_byp = resp_live && !redirect_i && (mq.size() == 0) && deq_ready_i;
`else
    m_byp = 1'b0;
`endif
    exp_valid = (mq.size() != 0) || m_byp;
    exp_pc    = m_byp ? pend[0].addr : ((mq.size() != 0) ? mq[0] : 32'h0);
  endtask

  task automatic advance();
    bit   grant, next_active;
    req_t r;
    next_active = start_i ? 1'b1 : ((pend.size() == 0) ? 1'b0 : m_active);
    grant = exp_req && imem_gnt_i;
    if (redirect_i) mq.delete();
    else begin
      if (exp_valid && deq_ready_i && !m_byp) void'(mq.pop_front());
      if (resp_live && !m_byp) mq.push_back(pend[0].addr);
    end
    if (imem_rvalid_i) void'(pend.pop_front());
    if (grant) begin
      r.addr = m_fetch_pc; r.epoch = epoch;
      r.due  = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redirect_i) begin
      m_fetch_pc = redirect_pc_i;
      epoch++;
    end
    m_active = next_active;
    @(posedge clk_i);
    #1 cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    rst_i = 1'b0; start_i = 1'b1;
    #2;
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req_o); end
    vectors++; if (deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", deq_valid_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d expected 0", count_o); end
    @(posedge clk_i); #1 rst_i = 1'b1;
    lat_min = 1; lat_max = 1; imem_gnt_i = 1'b1;
    prepare();
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b expected 0", imem_req_o); end
    vectors++; if (imem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL rst_addr: got %h expected %h", imem_addr_o, RESET_PC); end
    advance();
    prepare();
    vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL run_req: got %b expected 1", imem_req_o); end
    advance();
  endtask

  task automatic test_sequential();
    logic [31:0] want_addr, want_pc;
    do_reset();
    start_i = 1'b1; imem_gnt_i = 1'b1; deq_ready_i = 1'b1; lat_min = 1; lat_max = 1;
    want_addr = RESET_PC; want_pc = RESET_PC;
    for (int i = 0; i < 14; i++) begin
      prepare();
      vectors++;
      if (imem_req_o !== (i != 0)) begin miscompares++; $display("FAIL seq_req[%0d]: got %b expected %b", i, imem_req_o, i != 0); end
      if (imem_req_o === 1'b1) begin
        vectors++;
        if (imem_addr_o !== want_addr) begin miscompares++; $display("FAIL seq_addr: got %h expected %h", imem_addr_o, want_addr); end
        want_addr = want_addr + 32'd4;
      end
      if (i >= 3) begin
        vectors++;
        if (deq_valid_o !== 1'b1) begin miscompares++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, deq_valid_o); end
      end
      if (deq_valid_o === 1'b1) begin
        vectors++;
        if (deq_pc_o !== want_pc || deq_pc4_o !== want_pc + 32'd4 || deq_instr_o !== memf(want_pc)) begin
          miscompares++;
          $display("FAIL seq_deq: got pc %h pc4 %h instr %h expected %h %h %h", deq_pc_o, deq_pc4_o, deq_instr_o, want_pc, want_pc + 32'd4, memf(want_pc));
        end
        want_pc = want_pc + 32'd4;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int grants;
    do_reset();
    start_i = 1'b1; imem_gnt_i = 1'b1; deq_ready_i = 1'b0; lat_min = 1; lat_max = 1;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      prepare();
      if (imem_req_o === 1'b1 && imem_gnt_i) grants++;
      advance();
    end
    vectors++; if (grants != DEPTH) begin miscompares++; $display("FAIL bp_grants: got %0d expected %0d", grants, DEPTH); end
    deq_ready_i = 1'b1;
    prepare();
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL bp_req_full: got %b expected 0", imem_req_o); end
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL bp_count: got %0d expected 4", count_o); end
    vectors++; if (deq_pc_o !== RESET_PC) begin miscompares++; $display("FAIL bp_head: got %h expected %h", deq_pc_o, RESET_PC); end
    advance();
    deq_ready_i = 1'b0;
    prepare();
    vectors++; if (imem_req_o !== 1'b1) begin miscompares++; $display("FAIL bp_req_after_pop: got %b expected 1", imem_req_o); end
    vectors++; if (imem_addr_o !== RESET_PC + 32'h10) begin miscompares++; $display("FAIL bp_addr: got %h expected %h", imem_addr_o, RESET_PC + 32'h10); end
    vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL bp_count_pop: got %0d expected 3", count_o); end
    vectors++; if (deq_pc_o !== RESET_PC + 32'd4) begin miscompares++; $display("FAIL bp_head2: got %h expected %h", deq_pc_o, RESET_PC + 32'd4); end
    advance();
  endtask

  // Redirect and then wait (bounded) for the first delivered instruction.
  task automatic redirect_and_follow(input string tag, input logic [31:0] target);
    int  exp_disc;
    bit  seen;
    redirect_i = 1'b1; redirect_pc_i = target;
    prepare();
    exp_disc = pend.size() - (imem_rvalid_i ? 1 : 0);
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL %s_req_in_redirect: got %b expected 0", tag, imem_req_o); end
    advance();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; deq_ready_i = 1'b1;
    prepare();
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL %s_count: got %0d expected 0", tag, count_o); end
    vectors++; if (int'(u_dut.r_discard_cnt) != exp_disc) begin miscompares++; $display("FAIL %s_discard: got %0d expected %0d", tag, u_dut.r_discard_cnt, exp_disc); end
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (i != 0) prepare();
      if (deq_valid_o === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (deq_pc_o !== target || deq_instr_o !== memf(target)) begin
          miscompares++;
          $display("FAIL %s_first_pc: got %h/%h expected %h/%h", tag, deq_pc_o, deq_instr_o, target, memf(target));
        end
      end
      advance();
    end
    if (!seen) begin vectors++; miscompares++; $display("FAIL %s_timeout: got no delivery expected pc %h", tag, target); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    start_i = 1'b1; imem_gnt_i = 1'b1; deq_ready_i = 1'b1; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 4; i++) begin prepare(); advance(); end
    imem_gnt_i = 1'b0;
    redirect_and_follow("drain", 32'h400);
  endtask

  task automatic test_redirect_pop();
    bit found;
    do_reset();
    start_i = 1'b1; imem_gnt_i = 1'b1; deq_ready_i = 1'b0; lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prepare();
      if (count_o === 3'd2 && imem_rvalid_i) found = 1'b1;
      else advance();
    end
    if (!found) begin vectors++; miscompares++; $display("FAIL rp_setup: got no count=2 with rvalid expected one"); end
    else begin
      deq_ready_i = 1'b1;
      redirect_and_follow("rp", 32'h800);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    start_i = 1'b1; lat_min = 1; lat_max = 1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    prepare(); advance();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; deq_ready_i = 1'b1;
    prepare();
    vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %b/%h expected 1/fffffffc", imem_req_o, imem_addr_o); end
    advance();
    prepare();
    vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1: got %b/%h expected 1/00000000", imem_req_o, imem_addr_o); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (i != 0) prepare();
      if (deq_valid_o === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (deq_pc_o !== 32'hFFFF_FFFC || deq_pc4_o !== 32'h0) begin miscompares++; $display("FAIL wrap_pc4: got %h/%h expected fffffffc/00000000", deq_pc_o, deq_pc4_o); end
      end
      advance();
    end
    if (!seen) begin vectors++; miscompares++; $display("FAIL wrap_timeout: got no delivery expected one"); end
  endtask

  task automatic test_bypass();
    do_reset();
    start_i = 1'b1; deq_ready_i = 1'b1; lat_min = 2; lat_max = 2;
    prepare(); advance();
    imem_gnt_i = 1'b1; prepare(); advance();
    imem_gnt_i = 1'b0;
    prepare();
    vectors++; if (deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL byp_early: got %b expected 0", deq_valid_o); end
    advance();
    prepare();
`ifdef IFQ_BYPASS_EN
    vectors++; if (deq_valid_o !== 1'b1 || deq_pc_o !== RESET_PC || deq_instr_o !== memf(RESET_PC)) begin miscompares++; $display("FAIL byp_same_cycle: got %b/%h expected 1/%h", deq_valid_o, deq_pc_o, RESET_PC); end
    advance(); prepare();
    vectors++; if (count_o !== 3'd0 || deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL byp_after: got count %0d valid %b expected 0/0", count_o, deq_valid_o); end
`else
    vectors++; if (deq_valid_o !== 1'b0) begin miscompares++; $display("FAIL nobyp_same_cycle: got %b expected 0", deq_valid_o); end
    advance(); prepare();
    vectors++; if (deq_valid_o !== 1'b1 || deq_pc_o !== RESET_PC || count_o !== 3'd1) begin miscompares++; $display("FAIL nobyp_next: got %b/%h/%0d expected 1/%h/1", deq_valid_o, deq_pc_o, count_o, RESET_PC); end
`endif
    advance();
  endtask

  task automatic test_random(input int n);
    do_reset();
    start_i = 1'b1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < n; i++) begin
      imem_gnt_i    = ($urandom_range(3, 0) != 0);
      deq_ready_i   = ($urandom_range(2, 0) != 0);
      redirect_i    = ($urandom_range(24, 0) == 0);
      redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
      prepare();
      vectors++; if (imem_req_o !== exp_req) begin miscompares++; $display("FAIL rnd_req @%0d: got %b expected %b", cyc, imem_req_o, exp_req); end
      if (exp_req) begin
        vectors++; if (imem_addr_o !== m_fetch_pc) begin miscompares++; $display("FAIL rnd_addr @%0d: got %h expected %h", cyc, imem_addr_o, m_fetch_pc); end
      end
      vectors++; if (deq_valid_o !== exp_valid) begin miscompares++; $display("FAIL rnd_valid @%0d: got %b expected %b", cyc, deq_valid_o, exp_valid); end
      if (exp_valid) begin
        vectors++;
        if (deq_pc_o !== exp_pc || deq_instr_o !== memf(exp_pc) || deq_pc4_o !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL rnd_head @%0d: got %h/%h/%h expected %h/%h/%h", cyc, deq_pc_o, deq_instr_o, deq_pc4_o, exp_pc, memf(exp_pc), exp_pc + 32'd4);
        end
      end
      vectors++; if (int'(count_o) != mq.size() || count_o > 3'(DEPTH)) begin miscompares++; $display("FAIL rnd_count @%0d: got %0d expected %0d", cyc, count_o, mq.size()); end
      advance();
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_async_reset();
    test_random(60);
    #2 rst_i = 1'b0;
    #1;
    vectors++; if (imem_req_o !== 1'b0 || deq_valid_o !== 1'b0 || count_o !== 3'd0) begin miscompares++; $display("FAIL async_rst: got req %b valid %b count %0d expected 0/0/0", imem_req_o, deq_valid_o, count_o); end
    vectors++; if (imem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL async_rst_pc: got %h expected %h", imem_addr_o, RESET_PC); end
    @(posedge clk_i); #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_redirect_pop();
    test_wrap();
    test_bypass();
    test_random(400);
    test_async_reset();
    test_random(2500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1);
  end

endmodule

`default_nettype wire
